wires_to_bus_buf: RTL
=====================

Name: wires_to_bus_buf

Overview:
Gathers eight single-bit wires into one 8-bit bus, the inverse of the team's bus splitter, with registered buffering and a valid/ready handshake. A capture strobe samples the bit inputs into a small FIFO. The downstream bus consumer drains the FIFO at its own pace. Typical placement: between schematic-level bit signals (flags, switches, decoded lines) and an 8-bit datapath or peripheral bus of the Frankenstein core.

Parameters:
DEPTH, 2, number of FIFO entries; power of two, 2..16.
STICKY_OVF, 1, 1 = overflow flag holds until clear_ovf; 0 = overflow is a one-cycle pulse.

Ports:
clk  in  1  single clock; all state changes on rising edge
rst  in  1  synchronous, active-high reset
in_0 .. in_7  in  1 each  bit wires; in_k maps to bus bit k (in_0 = LSB)
capture  in  1  sample in_0..in_7 into the FIFO this cycle
out  out  8  head-of-FIFO byte; registered storage, not a combinational path from in_k
out_valid  out  1  FIFO non-empty
out_ready  in  1  consumer accepts out when out_valid && out_ready
full  out  1  FIFO holds DEPTH entries
level  out  $clog2(DEPTH)+1  current occupancy
overflow  out  1  capture was attempted while full and not popped the same cycle
clear_ovf  in  1  clears sticky overflow

Behaviour:
- Reset (rst=1 at clock edge): write pointer, read pointer and level go to 0; out_valid=0; full=0; overflow=0; out=8'h00. Storage contents are don't-care, but out is forced to 0 while empty. rst has priority over every other input.
- Byte assembly: word = {in_7,in_6,in_5,in_4,in_3,in_2,in_1,in_0}, sampled at the capture edge.
- Push: capture && (!full || pop). Pop: out_valid && out_ready.
- Latency: a byte captured at edge N is visible on out, with out_valid=1, after edge N when the FIFO was empty. There is no combinational path from capture to out_valid.
- Simultaneous push and pop:
  - When not empty, both happen and level is unchanged.
  - When full, the push is accepted because a slot frees the same cycle, and no overflow is raised.
  - When empty, only the push is possible, since pop requires out_valid.
- Overflow: capture && full && !pop drops the word. FIFO contents are unchanged.
  - STICKY_OVF=1: overflow sets and stays set until clear_ovf. If clear_ovf and a new overflow occur in the same cycle, overflow stays 1 (set wins).
  - STICKY_OVF=0: overflow is high for exactly the cycle after the dropped capture.
- Pointers wrap modulo DEPTH; level is tracked separately, range 0..DEPTH. full = (level==DEPTH); out_valid = (level!=0).
- out holds stable while out_valid && !out_ready; there is no change on a stall.
- Ordering: strict FIFO, and no entries are duplicated or lost except through overflow.
- Reset mid-operation discards all entries. The first capture after reset is the first byte delivered.
- capture while rst=1 is ignored.

Decomposition:
- Shared package (frank_bus_pkg): BYTE_W=8 and the byte typedef, reused by the bus splitter family.
- Natural sub-module: sync_fifo (generic DEPTH x BYTE_W storage, push/pop, level/full/empty). wires_to_bus_buf = bit concatenation + sync_fifo + overflow logic.

Test Plan:
1. Reset, then capture with in_7..in_0=1010_0101, out_ready=0 -> next cycle out=8'hA5, out_valid=1, level=1; out stays 8'hA5 for 5 stalled cycles.
2. DEPTH=2: capture 8'h01, then 8'h02 -> full=1, level=2. A third capture of 8'h03 with out_ready=0 -> overflow=1 (sticky). Drain gives 8'h01 then 8'h02; clear_ovf -> overflow=0.
3. Full FIFO with capture=1 and out_ready=1 in the same cycle (new 8'h7F) -> overflow stays 0, level stays 2, output order 8'h01, 8'h02, 8'h7F.
4. Streaming: capture every cycle with out_ready=1, inputs 8'h00..8'hFF incrementing -> out reproduces all 256 values in order, level never above 1, overflow=0.
5. Reset asserted with level=2 and capture=1 -> next cycle out_valid=0, level=0, out=8'h00, overflow=0; captured value not stored.
6. STICKY_OVF=0: overflow on a full FIFO -> overflow=1 for exactly one cycle. Same cycle clear_ovf=1 with sticky build and new overflow -> overflow remains 1.

Source files
------------

// File: rtl/frank_bus_pkg.sv
// Shared byte-bus definitions for the splitter/gatherer family of the Frankenstein core.
package frank_bus_pkg;

   localparam int unsigned BYTE_W = 8;

   typedef logic [BYTE_W-1:0] byte_t;

   // Bit k of the result is wire k, so b0 lands on the LSB.
   function automatic byte_t gather_bits(
      input logic b0, input logic b1, input logic b2, input logic b3,
      input logic b4, input logic b5, input logic b6, input logic b7
   );
      return {b7, b6, b5, b4, b3, b2, b1, b0};
   endfunction

endpackage

// File: rtl/wires_to_bus_buf_if.sv
// Bit-wire inputs plus the buffered byte bus and its valid/ready handshake.
interface wires_to_bus_buf_if #(
   parameter int unsigned DEPTH = 2
);
   import frank_bus_pkg::*;

   logic                   in_0;
   logic                   in_1;
   logic                   in_2;
   logic                   in_3;
   logic                   in_4;
   logic                   in_5;
   logic                   in_6;
   logic                   in_7;
   logic                   capture;
   byte_t                  out;
   logic                   out_valid;
   logic                   out_ready;
   logic                   full;
   logic [$clog2(DEPTH):0] level;
   logic                   overflow;
   logic                   clear_ovf;

   // Driver side: the bit sources and the byte consumer.
   modport master (
      output in_0, in_1, in_2, in_3, in_4, in_5, in_6, in_7,
      output capture, out_ready, clear_ovf,
      input  out, out_valid, full, level, overflow
   );

   // The gathering buffer itself.
   modport slave (
      input  in_0, in_1, in_2, in_3, in_4, in_5, in_6, in_7,
      input  capture, out_ready, clear_ovf,
      output out, out_valid, full, level, overflow
   );

endinterface

// File: rtl/wires_to_bus_buf_sync_fifo.sv
// Generic single-clock FIFO: DEPTH (power of two) entries, level tracked apart from pointers.
module sync_fifo #(
   parameter int unsigned DEPTH = 2,
   parameter int unsigned WIDTH = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push,
   input  logic                   pop,
   input  logic [WIDTH-1:0]       wdata,
   output logic [WIDTH-1:0]       rdata,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] level
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      cnt;
   logic             do_push;
   logic             do_pop;

   // A push into a full FIFO is still accepted when a pop frees a slot on the same edge.
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);

   assign full  = (cnt == FULL_CNT);
   assign empty = (cnt == '0);
   assign level = cnt;
   assign rdata = empty ? '0 : mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   cnt <= cnt + 1'b1;
            2'b01:   cnt <= cnt - 1'b1;
            default: cnt <= cnt;
         endcase
      end
   end

   // Storage carries no reset; contents are masked by the empty check on rdata.
   always_ff @(posedge clk) begin
      if (!rst && do_push) mem[wr_ptr] <= wdata;
   end

endmodule

// File: rtl/wires_to_bus_buf.sv
// Gathers eight bit wires into a byte, buffers captures in a FIFO, flags dropped captures.
module wires_to_bus_buf
   import frank_bus_pkg::*;
#(
   parameter int unsigned DEPTH      = 2,
   parameter bit          STICKY_OVF = 1'b1
) (
   input  logic               clk,
   input  logic               rst,
   wires_to_bus_buf_if.slave  bus
);

   byte_t                  word;
   byte_t                  head;
   logic                   fifo_full;
   logic                   fifo_empty;
   logic [$clog2(DEPTH):0] fifo_level;
   logic                   pop;
   logic                   drop;
   logic                   ovf_q;

   assign word = gather_bits(bus.in_0, bus.in_1, bus.in_2, bus.in_3,
                             bus.in_4, bus.in_5, bus.in_6, bus.in_7);

   assign pop  = !fifo_empty && bus.out_ready;
   assign drop = bus.capture && fifo_full && !pop;

   sync_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (BYTE_W)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (bus.capture),
      .pop   (pop),
      .wdata (word),
      .rdata (head),
      .full  (fifo_full),
      .empty (fifo_empty),
      .level (fifo_level)
   );

   // Sticky mode: a new drop outranks clear_ovf arriving on the same edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         ovf_q <= 1'b0;
      end else if (STICKY_OVF) begin
         if (drop)               ovf_q <= 1'b1;
         else if (bus.clear_ovf) ovf_q <= 1'b0;
      end else begin
         ovf_q <= drop;
      end
   end

   assign bus.out       = head;
   assign bus.out_valid = !fifo_empty;
   assign bus.full      = fifo_full;
   assign bus.level     = fifo_level;
   assign bus.overflow  = ovf_q;

endmodule
